// File: rtl/bram_write_arbiter_if.sv
// Bundle of the requester handshake and BRAM write port for bram_write_arbiter.
//   slave  : arbiter side (takes req_valid_i/req_data_i, drives ready, done and BRAM port)
//   master : requester/BRAM side (drives req_valid_i/req_data_i, observes the rest)
// Signals:
//   req_valid_i [NUM_REQ]               per-requester result valid
//   req_data_i  [NUM_REQ*DATA_IN_WIDTH] results, requester i at [i*DATA_IN_WIDTH +: DATA_IN_WIDTH]
//   req_ready_o [NUM_REQ]               per-requester accept (combinational)
//   done_o      [NUM_REQ]               one-cycle pulse when a result is fully written
//   bram_addr/bram_data/bram_en/bram_we BRAM write port (registered)
interface bram_write_arbiter_if #(
    parameter int NUM_REQ        = 4,
    parameter int ADDRESS_WIDTH  = 13,
    parameter int DATA_IN_WIDTH  = 512,
    parameter int DATA_OUT_WIDTH = 32
);
    logic [NUM_REQ-1:0]               req_valid_i;
    logic [NUM_REQ*DATA_IN_WIDTH-1:0] req_data_i;
    logic [NUM_REQ-1:0]               req_ready_o;
    logic [NUM_REQ-1:0]               done_o;
    logic [ADDRESS_WIDTH-1:0]         bram_addr;
    logic [DATA_OUT_WIDTH-1:0]        bram_data;
    logic                             bram_en;
    logic                             bram_we;

    modport slave (
        input  req_valid_i, req_data_i,
        output req_ready_o, done_o, bram_addr, bram_data, bram_en, bram_we
    );

    modport master (
        output req_valid_i, req_data_i,
        input  req_ready_o, done_o, bram_addr, bram_data, bram_en, bram_we
    );
endinterface

// File: rtl/bram_write_arbiter.sv
// Round-robin arbiter that serialises wide per-requester results into a BRAM,
// one DATA_OUT_WIDTH word per cycle, least-significant word first. Each
// requester owns a REGION_WORDS-deep ring in the BRAM starting at
// BASE_ADDRESS + id*REGION_WORDS with its own wrapping write pointer.
// Ports:
//   clk_i       sole clock, rising edge
//   rst_i       asynchronous active-low reset
//   en_i        global enable for new grants (running bursts always finish)
//   bus         bram_write_arbiter_if.slave: request handshake + BRAM write port
//   busy_o      high whenever the FSM is not in IDLE
//   grant_id_o  current / last granted requester
//
// state | meaning
// IDLE  | waiting for a valid request while en_i=1; ready asserted combinationally
// WRITE | streaming words of the captured result to the BRAM
// DONE  | write port idle, done_o pulse for the granted requester
module bram_write_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDRESS_WIDTH  = 13,
    parameter int DATA_IN_WIDTH  = 512,
    parameter int DATA_OUT_WIDTH = 32,
    parameter int BASE_ADDRESS   = 5,
    parameter int REGION_WORDS   = 256
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en_i,
    bram_write_arbiter_if.slave        bus,
    output logic                       busy_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int W     = DATA_IN_WIDTH / DATA_OUT_WIDTH;
    localparam int CNT_W = $clog2(W) + 1;
    localparam int PTR_W = $clog2(REGION_WORDS);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t                    state_q;
    logic [ID_W-1:0]           grant_id_q;
    logic [ID_W-1:0]           last_grant_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [DATA_IN_WIDTH-1:0]  shreg_q;
    logic [PTR_W-1:0]          ptr_q [NUM_REQ];

    logic                      sel_found;
    logic [ID_W-1:0]           sel_id;
    logic [DATA_IN_WIDTH-1:0]  sel_data;
    logic                      accept;
    logic [ID_W-1:0]           wr_id;
    logic [ADDRESS_WIDTH-1:0]  wr_addr;
    int                        idx;

    // Round-robin search starting just after the last completed grant.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant_q) + k) % NUM_REQ;
            if (!sel_found && bus.req_valid_i[ID_W'(idx)]) begin
                sel_found = 1'b1;
                sel_id    = ID_W'(idx);
            end
        end
    end

    assign accept          = (state_q == IDLE) && en_i && sel_found;
    assign bus.req_ready_o = accept ? (NUM_REQ'(1) << sel_id) : '0;
    assign sel_data        = bus.req_data_i[int'(sel_id)*DATA_IN_WIDTH +: DATA_IN_WIDTH];

    // Word 0 is written on the accepting edge, so the address must use the
    // requester being selected rather than the registered grant.
    assign wr_id   = (state_q == IDLE) ? sel_id : grant_id_q;
    assign wr_addr = ADDRESS_WIDTH'(BASE_ADDRESS)
                   + ADDRESS_WIDTH'(REGION_WORDS * int'(wr_id))
                   + ADDRESS_WIDTH'(ptr_q[wr_id]);

    assign busy_o     = (state_q != IDLE);
    assign grant_id_o = grant_id_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= IDLE;
            grant_id_q    <= '0;
            last_grant_q  <= ID_W'(NUM_REQ - 1);
            cnt_q         <= '0;
            shreg_q       <= '0;
            for (int i = 0; i < NUM_REQ; i++) ptr_q[i] <= '0;
            bus.bram_addr <= ADDRESS_WIDTH'(BASE_ADDRESS);
            bus.bram_data <= '0;
            bus.bram_en   <= 1'b0;
            bus.bram_we   <= 1'b0;
            bus.done_o    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        bus.bram_en    <= 1'b1;
                        bus.bram_we    <= 1'b1;
                        bus.bram_addr  <= wr_addr;
                        bus.bram_data  <= sel_data[DATA_OUT_WIDTH-1:0];
                        shreg_q        <= sel_data >> DATA_OUT_WIDTH;
                        // cnt_q counts words still to be written after this one
                        cnt_q          <= CNT_W'(W - 1);
                        grant_id_q     <= sel_id;
                        ptr_q[sel_id]  <= ptr_q[sel_id] + PTR_W'(1);
                        state_q        <= WRITE;
                    end
                end
                WRITE: begin
                    if (cnt_q != '0) begin
                        bus.bram_addr     <= wr_addr;
                        bus.bram_data     <= shreg_q[DATA_OUT_WIDTH-1:0];
                        shreg_q           <= shreg_q >> DATA_OUT_WIDTH;
                        cnt_q             <= cnt_q - CNT_W'(1);
                        ptr_q[grant_id_q] <= ptr_q[grant_id_q] + PTR_W'(1);
                    end else begin
                        bus.bram_en  <= 1'b0;
                        bus.bram_we  <= 1'b0;
                        bus.done_o   <= NUM_REQ'(1) << grant_id_q;
                        last_grant_q <= grant_id_q;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    bus.done_o <= '0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bram_write_arbiter.sv
// Scoreboard bench for bram_write_arbiter. A cycle-level reference model
// (round-robin pick, per-region pointers, burst timing by cycle arithmetic)
// runs in the monitor; expected BRAM writes and done pulses are queued with
// their due cycle and compared as the DUT presents them.
module tb_bram_write_arbiter;
    localparam int NUM_REQ = 4;
    localparam int AW      = 13;
    localparam int DI      = 512;
    localparam int DO      = 32;
    localparam int BASE    = 5;
    localparam int RW      = 256;
    localparam int W       = DI / DO;
    localparam int IDW     = $clog2(NUM_REQ);

    logic           clk_i = 1'b0;
    logic           rst_i = 1'b0;
    logic           en_i  = 1'b0;
    logic           busy_o;
    logic [IDW-1:0] grant_id_o;

    bram_write_arbiter_if #(
        .NUM_REQ(NUM_REQ), .ADDRESS_WIDTH(AW),
        .DATA_IN_WIDTH(DI), .DATA_OUT_WIDTH(DO)
    ) bus ();

    bram_write_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDRESS_WIDTH(AW), .DATA_IN_WIDTH(DI),
        .DATA_OUT_WIDTH(DO), .BASE_ADDRESS(BASE), .REGION_WORDS(RW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .bus(bus),
        .busy_o(busy_o), .grant_id_o(grant_id_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct { int cyc; logic [AW-1:0] addr; logic [DO-1:0] data; } wr_t;
    typedef struct { int cyc; int id; } dn_t;
    wr_t wq[$];
    dn_t dq[$];

    int n_checks = 0;
    int n_fail   = 0;

    int m_free = 0;
    int m_acc  = -1;
    int m_last = NUM_REQ - 1;
    int m_cur  = 0;
    int m_ptr [NUM_REQ];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int rr_pick(logic [NUM_REQ-1:0] v, int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            int i;
            i = (last + k) % NUM_REQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    always @(negedge clk_i) begin : monitor
        logic [NUM_REQ-1:0] exp_ready;
        logic [NUM_REQ-1:0] exp_done;
        wr_t e;
        int  id;
        if (!rst_i) begin
            check("rst_bram_en", 64'(bus.bram_en), 64'd0);
            check("rst_bram_we", 64'(bus.bram_we), 64'd0);
            check("rst_done", 64'(bus.done_o), 64'd0);
            check("rst_busy", 64'(busy_o), 64'd0);
            check("rst_grant_id", 64'(grant_id_o), 64'd0);
            check("rst_bram_addr", 64'(bus.bram_addr), 64'(BASE));
            check("rst_bram_data", 64'(bus.bram_data), 64'd0);
            m_free = 0;
            m_acc  = -1;
            m_last = NUM_REQ - 1;
            for (int i = 0; i < NUM_REQ; i++) m_ptr[i] = 0;
            wq.delete();
            dq.delete();
        end else begin
            check("busy", 64'(busy_o), 64'((cyc > m_acc) && (cyc < m_free)));
            if ((cyc > m_acc) && (cyc < m_free))
                check("grant_id", 64'(grant_id_o), 64'(m_cur));

            if (wq.size() > 0 && wq[0].cyc == cyc) begin
                e = wq.pop_front();
                check("bram_en", 64'(bus.bram_en), 64'd1);
                check("bram_we", 64'(bus.bram_we), 64'd1);
                check("bram_addr", 64'(bus.bram_addr), 64'(e.addr));
                check("bram_data", 64'(bus.bram_data), 64'(e.data));
            end else begin
                check("bram_en_idle", 64'(bus.bram_en), 64'd0);
                check("bram_we_idle", 64'(bus.bram_we), 64'd0);
            end

            exp_done = '0;
            if (dq.size() > 0 && dq[0].cyc == cyc) begin
                exp_done[dq[0].id] = 1'b1;
                void'(dq.pop_front());
            end
            check("done", 64'(bus.done_o), 64'(exp_done));

            exp_ready = '0;
            if (cyc >= m_free && en_i && (|bus.req_valid_i)) begin
                id = rr_pick(bus.req_valid_i, m_last);
                exp_ready[id] = 1'b1;
                for (int k = 0; k < W; k++) begin
                    e.cyc  = cyc + 1 + k;
                    e.addr = AW'(BASE + id * RW + m_ptr[id]);
                    e.data = bus.req_data_i[id*DI + k*DO +: DO];
                    wq.push_back(e);
                    m_ptr[id] = (m_ptr[id] + 1) % RW;
                end
                dq.push_back('{cyc: cyc + W + 1, id: id});
                m_acc  = cyc;
                m_free = cyc + W + 2;
                m_cur  = id;
                m_last = id;
            end
            check("ready", 64'(bus.req_ready_o), 64'(exp_ready));
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic seq_data();
        for (int i = 0; i < NUM_REQ; i++)
            for (int k = 0; k < W; k++)
                bus.req_data_i[i*DI + k*DO +: DO] = DO'(k + 1);
    endtask

    task automatic rand_data();
        for (int j = 0; j < NUM_REQ*DI/32; j++)
            bus.req_data_i[j*32 +: 32] = $urandom;
    endtask

    initial begin
        bus.req_valid_i = '0;
        bus.req_data_i  = '0;
        repeat (3) tick();
        rst_i = 1'b1;
        en_i  = 1'b1;

        // single request, word k = k+1
        seq_data();
        bus.req_valid_i = 4'b0001;
        tick();
        bus.req_valid_i = '0;
        repeat (W + 4) tick();

        // contention
        rand_data();
        bus.req_valid_i = 4'b1111;
        repeat (5 * (W + 2)) tick();
        bus.req_valid_i = '0;
        repeat (W + 4) tick();

        // pointer wrap on requester 0
        bus.req_valid_i = 4'b0001;
        repeat (18) begin
            rand_data();
            repeat (W + 2) tick();
        end
        bus.req_valid_i = '0;
        repeat (W + 4) tick();

        // enable dropped mid-burst
        bus.req_valid_i = 4'b0010;
        tick();
        bus.req_valid_i = '0;
        repeat (4) tick();
        en_i = 1'b0;
        bus.req_valid_i = 4'b1111;
        repeat (W + 6) tick();
        en_i = 1'b1;
        repeat (2 * (W + 2)) tick();
        bus.req_valid_i = '0;
        repeat (W + 4) tick();

        // reset mid-burst
        rand_data();
        bus.req_valid_i = 4'b1000;
        tick();
        bus.req_valid_i = '0;
        repeat (7) tick();
        rst_i = 1'b0;
        repeat (2) tick();
        rst_i = 1'b1;
        bus.req_valid_i = 4'b1000;
        tick();
        bus.req_valid_i = '0;
        repeat (W + 4) tick();

        // withdrawn request during another burst
        bus.req_valid_i = 4'b0001;
        tick();
        bus.req_valid_i = '0;
        repeat (3) tick();
        bus.req_valid_i = 4'b0100;
        tick();
        bus.req_valid_i = '0;
        repeat (W + 6) tick();

        // random traffic with occasional resets
        repeat (3000) begin
            bus.req_valid_i = NUM_REQ'($urandom);
            en_i  = ($urandom_range(0, 7) != 0);
            rst_i = ($urandom_range(0, 599) != 0);
            if ($urandom_range(0, 15) == 0) rand_data();
            tick();
        end
        rst_i = 1'b1;
        en_i  = 1'b1;
        bus.req_valid_i = '0;
        repeat (W + 6) tick();

        check("queue_drain", 64'(wq.size() + dq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bram_write_arbiter.md
BRAM_WRITE_ARBITER -- requirements
Module: bram_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of result requesters (2..8).
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 13, BRAM word address width.
REQ-003 SHALL have parameter DATA_IN_WIDTH, default 512, result width per requester.
REQ-004 SHALL have parameter DATA_OUT_WIDTH, default 32, BRAM word width; DATA_IN_WIDTH is an integer multiple of it.
REQ-005 SHALL have parameter BASE_ADDRESS, default 5, first word address of requester 0's region.
REQ-006 SHALL have parameter REGION_WORDS, default 256, words per requester region (power of two); BASE_ADDRESS+NUM_REQ*REGION_WORDS <= 2^ADDRESS_WIDTH.
REQ-007 SHALL have ports: clk_i  in  1  sole clock, rising edge.
REQ-008 SHALL have ports: rst_i  in  1  reset, asynchronous, active-low.
REQ-009 SHALL have ports: en_i  in  1  global enable for new grants.
REQ-010 SHALL have ports: req_valid_i  in  NUM_REQ  per-requester result valid.
REQ-011 SHALL have ports: req_data_i  in  NUM_REQ*DATA_IN_WIDTH  results, requester i at bits [i*DATA_IN_WIDTH +: DATA_IN_WIDTH].
REQ-012 SHALL have ports: req_ready_o  out  NUM_REQ  per-requester accept.
REQ-013 SHALL have ports: done_o  out  NUM_REQ  one-cycle pulse, result fully written.
REQ-014 SHALL have ports: bram_addr  out  ADDRESS_WIDTH, bram_data  out  DATA_OUT_WIDTH, bram_en  out  1, bram_we  out  1.
REQ-015 SHALL have ports: busy_o  out  1  high outside IDLE; grant_id_o  out  clog2(NUM_REQ)  current/last granted requester.

Function
REQ-016 SHALL implement FSM states IDLE, WRITE, DONE.
REQ-017 In IDLE with en_i=1 and any req_valid_i, SHALL select one requester round-robin, searching from (last_grant+1) mod NUM_REQ upward.
REQ-018 req_ready_o[i] SHALL be combinational: 1 only in IDLE, en_i=1, req_valid_i[i]=1, i selected; at most one bit high.
REQ-019 On valid&ready (cycle T) SHALL capture the result into a shift register, load word counter W=DATA_IN_WIDTH/DATA_OUT_WIDTH, set grant_id_o, enter WRITE.
REQ-020 In WRITE, each cycle SHALL register bram_en=1, bram_we=1, bram_data=least-significant unwritten word, bram_addr=BASE_ADDRESS+id*REGION_WORDS+ptr[id]; first write visible at T+1, last (word W-1) at T+W.
REQ-021 Word order SHALL be least-significant word first; the shift register shifts right by DATA_OUT_WIDTH per write.
REQ-022 Per-requester write pointer ptr[id] SHALL increment per written word and wrap REGION_WORDS-1 -> 0; other pointers unchanged.
REQ-023 After the last word SHALL enter DONE: bram_en=0, bram_we=0, done_o[id]=1 for exactly one cycle (T+W+1), last_grant=id, then IDLE.
REQ-024 Outside WRITE, bram_en and bram_we SHALL be 0; bram_addr and bram_data hold last value.
REQ-025 Throughput SHALL be one result per W+2 cycles; no grant in DONE.
REQ-026 en_i=0 SHALL block new grants only; an in-progress burst completes unchanged.
REQ-027 req_valid_i deasserted before acceptance SHALL have no effect; req_valid_i/req_data_i changes after acceptance SHALL not affect the burst.
REQ-028 Simultaneous valids SHALL be served one per burst in round-robin order; no requester waits more than NUM_REQ-1 bursts.

Reset
REQ-029 On rst_i=0 (any state, including mid-burst) SHALL immediately: state=IDLE, all ptr=0, last_grant=NUM_REQ-1, counter=0, shift register=0, bram_addr=BASE_ADDRESS, bram_data=0, bram_en=0, bram_we=0, done_o=0, busy_o=0, grant_id_o=0; partial burst discarded, no done_o.

Verification
REQ-030 Single: reset, en_i=1, req_valid_i=4'b0001, data word k = k+1 -> ready[0] at T; writes at T+1..T+16, addr 5..20, data 1..16; done_o=4'b0001 at T+17.
REQ-031 Contention: all four valid continuously -> grant order 0,1,2,3,0; requester 1's first addr 261, requester 3's 773; done pulses 18 cycles apart.
REQ-032 Wrap: 17 results from requester 0 -> 17th result writes addrs 5..20 again (ptr 256 -> 0 wrap after 16 results).
REQ-033 Enable: drop en_i at T+5 of a burst -> burst completes, done_o pulses, no new ready while en_i=0; restore -> grant resumes.
REQ-034 Reset mid-burst at T+8 -> bram_en=0 same cycle; no done_o; next burst for that requester starts at its region base.
REQ-035 Withdrawn request: valid[2] high one cycle while another burst runs, then low -> requester 2 never granted, no write to region 2.
